caliptra_axil_apb_bridge: RTL and testbench
===========================================

Name: caliptra_axil_apb_bridge

Overview:
- APB4 requester for the FPGA build. Converts single-beat AXI4-Lite transactions from the PS/host interconnect into APB4 transfers driving Caliptra's APB completer port.
- Sits between the host AXI4-Lite master and the Caliptra APB slave inside the FPGA wrapper. Lets the host drive mailbox and SoC-interface registers without a vendor IP bridge.
- Exactly one transaction in flight. Includes a PREADY timeout so a hung completer cannot stall the host.

Parameters:
- ADDR_W, 32, width of AXI address and PADDR.
- DATA_W, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 1024, maximum ACCESS-phase cycles before forced termination; 0 disables the timeout.

Ports:
- core_clk  in  1  sole clock; all logic is on the rising edge.
- core_rst  in  1  synchronous, active-high reset.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awprot  in  3  write protection attributes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  write byte strobes.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_bresp  out  2  write response code.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arprot  in  3  read protection attributes.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response code.
- m_apb_psel  out  1  APB select.
- m_apb_penable  out  1  APB enable.
- m_apb_pwrite  out  1  APB direction, 1 = write.
- m_apb_paddr  out  ADDR_W  APB address.
- m_apb_pprot  out  3  APB protection.
- m_apb_pstrb  out  4  APB write strobes.
- m_apb_pwdata  out  32  APB write data.
- m_apb_prdata  in  32  APB read data.
- m_apb_pready  in  1  APB ready.
- m_apb_pslverr  in  1  APB slave error.

Behaviour:
- Reset:
  - All ready, valid, psel and penable outputs are 0.
  - paddr, pwdata, pstrb, pprot, pwrite, rdata, bresp and rresp are 0.
  - FSM is in IDLE; arbitration flag last_was_write=1, so a read wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A write is pending only when awvalid and wvalid are both high. AW alone or W alone is not accepted; no ready is raised.
  - A read is pending when arvalid is high.
  - If both are pending, round-robin: grant the opposite of last_was_write.
  - Grant cycle: awready and wready (or arready) are combinationally high for exactly that cycle. Address, prot, data and strb are captured at that edge.
  - last_was_write is updated at the grant. Next state is SETUP.
- SETUP (one cycle):
  - psel=1, penable=0.
  - paddr = captured address with bits[1:0] forced to 0.
  - pwrite set per direction; pprot = AxPROT.
  - pstrb = wstrb on writes, 0 on reads. pwdata = wdata on writes, 0 on reads.
  - Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1; every APB output is held stable.
  - The timeout counter increments each cycle that pready is low.
  - When pready is high: sample prdata and pslverr (pslverr is ignored when pready is low). Response = 2'b10 SLVERR if pslverr, else 2'b00 OKAY. Go to RESP.
  - Timeout: if the counter reaches TIMEOUT_CYCLES with pready still low, response = 2'b11 DECERR and rdata = 32'h0. Go to RESP.
  - psel and penable drop to 0 on the cycle after completion.
  - The timeout counter clears on entry to ACCESS.
- RESP:
  - bvalid (write) or rvalid (read) is high, with bresp/rresp and rdata stable.
  - Stay in RESP until the matching ready is high, then return to IDLE.
  - rdata keeps its last value outside RESP.
- Latency, zero-wait completer:
  - Grant at cycle N; psel at N+1; penable at N+2; with pready at N+2, valid at N+3.
  - With bready/rready held high, IDLE is re-entered at N+4; back-to-back throughput is 1 transaction per 4 cycles.
- Reset mid-operation:
  - Synchronous return to IDLE at that edge; psel, penable and valids drop.
  - The in-flight transaction is abandoned and no response is issued.
- Unused address bits beyond ADDR_W do not exist; callers truncate.

Decomposition:
- Package caliptra_axil_apb_pkg holds:
  - the FSM state enum (bridge_state_e);
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the captured-request struct (addr, prot, data, strb, write).
- No sub-module: the timeout counter and arbiter are small enough to stay inline.

Test Plan:
- Write 0x3000_0010 / 0xA5A5_5A5A / wstrb 0xF, pready tied high:
  - psel rises at N+1 with penable 0; paddr=0x3000_0010, pstrb=0xF.
  - bvalid at N+3 with bresp=0.
- Read 0x3000_0020 with pready delayed 5 ACCESS cycles, prdata=0x1234_5678:
  - APB outputs stay stable throughout.
  - rvalid one cycle after pready; rdata=0x1234_5678, rresp=0.
- Write with pslverr=1 at pready -> bresp=2'b10. Read with pslverr=1 -> rresp=2'b10.
- TIMEOUT_CYCLES=16, pready held low:
  - DECERR after 16 ACCESS cycles; rdata=0.
  - psel drops; the next transaction proceeds normally.
- awvalid, wvalid and arvalid all held high continuously from reset:
  - Grants alternate R, W, R, W.
  - awvalid without wvalid -> awready never asserts.
- core_rst asserted during ACCESS:
  - psel, penable and valids are 0 the next cycle; no bvalid or rvalid follows.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/caliptra_axil_apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_axil_apb_pkg
// Brief    : Shared types and response codes for the AXI4-Lite to APB4 bridge.
// Revision : 1.0
// ============================================================================
package caliptra_axil_apb_pkg;

  localparam int BRIDGE_ADDR_W = 32;
  localparam int BRIDGE_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  typedef struct packed {
    logic [BRIDGE_ADDR_W-1:0] addr;
    logic [2:0]               prot;
    logic [BRIDGE_DATA_W-1:0] data;
    logic [3:0]               strb;
    logic                     write;
  } bridge_req_t;

endpackage
`default_nettype wire

// File: rtl/caliptra_axil_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_axil_apb_bridge
// Brief    : Single-outstanding AXI4-Lite to APB4 requester with PREADY timeout.
// Revision : 1.0
// ============================================================================
module caliptra_axil_apb_bridge
  import caliptra_axil_apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]          s_axil_awprot,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  input  logic [DATA_W-1:0]   s_axil_wdata,
  input  logic [DATA_W/8-1:0] s_axil_wstrb,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  output logic [1:0]          s_axil_bresp,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  input  logic [ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]          s_axil_arprot,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic [DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                m_apb_psel,
  output logic                m_apb_penable,
  output logic                m_apb_pwrite,
  output logic [ADDR_W-1:0]   m_apb_paddr,
  output logic [2:0]          m_apb_pprot,
  output logic [DATA_W/8-1:0] m_apb_pstrb,
  output logic [DATA_W-1:0]   m_apb_pwdata,
  input  logic [DATA_W-1:0]   m_apb_prdata,
  input  logic                m_apb_pready,
  input  logic                m_apb_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_e     state_q, state_d;
  bridge_req_t       req_q, req_d;
  logic              last_was_write_q, last_was_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic wr_pending, rd_pending, grant_wr, grant_rd, timeout_hit, resp_ready;

  assign wr_pending = s_axil_awvalid & s_axil_wvalid;
  assign rd_pending = s_axil_arvalid;

  // Round-robin on a tie: the direction not served last time wins.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_pending && rd_pending) begin
        grant_wr = ~last_was_write_q;
        grant_rd = last_was_write_q;
      end else begin
        grant_wr = wr_pending;
        grant_rd = rd_pending;
      end
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without PREADY.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !m_apb_pready && (cnt_q == TMO_LAST);
  assign resp_ready  = req_q.write ? s_axil_bready : s_axil_rready;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q          <= ST_IDLE;
      req_q            <= '0;
      last_was_write_q <= 1'b1;
      rdata_q          <= '0;
      resp_q           <= RESP_OKAY;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      last_was_write_q <= last_was_write_d;
      rdata_q          <= rdata_d;
      resp_q           <= resp_d;
      cnt_q            <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    last_was_write_d = last_was_write_q;
    rdata_d          = rdata_q;
    resp_d           = resp_q;
    cnt_d            = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          req_d.addr       = BRIDGE_ADDR_W'(s_axil_awaddr & ~ADDR_W'(3));
          req_d.prot       = s_axil_awprot;
          req_d.data       = BRIDGE_DATA_W'(s_axil_wdata);
          req_d.strb       = 4'(s_axil_wstrb);
          req_d.write      = 1'b1;
          last_was_write_d = 1'b1;
          state_d          = ST_SETUP;
        end else if (grant_rd) begin
          req_d.addr       = BRIDGE_ADDR_W'(s_axil_araddr & ~ADDR_W'(3));
          req_d.prot       = s_axil_arprot;
          req_d.data       = '0;
          req_d.strb       = '0;
          req_d.write      = 1'b0;
          last_was_write_d = 1'b0;
          state_d          = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_apb_pready) begin
          resp_d  = m_apb_pslverr ? RESP_SLVERR : RESP_OKAY;
          if (!req_q.write) rdata_d = m_apb_prdata;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          resp_d  = RESP_DECERR;
          if (!req_q.write) rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axil_awready = grant_wr;
    s_axil_wready  = grant_wr;
    s_axil_arready = grant_rd;
    s_axil_bvalid  = (state_q == ST_RESP) &&  req_q.write;
    s_axil_rvalid  = (state_q == ST_RESP) && !req_q.write;
    s_axil_bresp   = resp_q;
    s_axil_rresp   = resp_q;
    s_axil_rdata   = rdata_q;
    m_apb_psel     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    m_apb_penable  = (state_q == ST_ACCESS);
    m_apb_pwrite   = req_q.write;
    m_apb_paddr    = ADDR_W'(req_q.addr);
    m_apb_pprot    = req_q.prot;
    m_apb_pstrb    = STRB_W'(req_q.strb);
    m_apb_pwdata   = DATA_W'(req_q.data);
  end

endmodule
`default_nettype wire

// File: tb/tb_caliptra_axil_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_caliptra_axil_apb_bridge
// Brief    : Directed self-checking bench for the AXI4-Lite to APB4 bridge.
// Revision : 1.0
// ============================================================================
module tb_caliptra_axil_apb_bridge;

  logic        core_clk, core_rst;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pready, m_apb_pslverr;
  logic [31:0] m_apb_paddr, m_apb_pwdata, m_apb_prdata;
  logic [2:0]  m_apb_pprot;
  logic [3:0]  m_apb_pstrb;

  int checks   = 0;
  int failures = 0;

  caliptra_axil_apb_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
    .m_apb_pwrite(m_apb_pwrite), .m_apb_paddr(m_apb_paddr),
    .m_apb_pprot(m_apb_pprot), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pwdata(m_apb_pwdata), .m_apb_prdata(m_apb_prdata),
    .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_reset();
    core_rst = 1'b1;
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    s_axil_awaddr = '0; s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_awprot = '0;
    s_axil_araddr = '0; s_axil_arprot = '0;
    s_axil_bready = 1; s_axil_rready = 1;
    m_apb_pready = 0; m_apb_pslverr = 0; m_apb_prdata = '0;
    tick(); tick();
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
         m_apb_psel, m_apb_penable, m_apb_pwrite} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000000", {s_axil_awready, s_axil_wready,
               s_axil_arready, s_axil_bvalid, s_axil_rvalid, m_apb_psel, m_apb_penable, m_apb_pwrite});
    end
    checks++;
    if ({m_apb_paddr, m_apb_pwdata, m_apb_pstrb, m_apb_pprot, s_axil_rdata, s_axil_bresp,
         s_axil_rresp} !== '0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h pprot=%h rdata=%h bresp=%b rresp=%b want all 0",
               m_apb_paddr, m_apb_pwdata, m_apb_pstrb, m_apb_pprot, s_axil_rdata, s_axil_bresp, s_axil_rresp);
    end
    core_rst = 1'b0;
  endtask

  task automatic test_write_zero_wait();
    m_apb_pready = 1; m_apb_pslverr = 0;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    s_axil_awaddr = 32'h3000_0013; s_axil_awprot = 3'b010;
    s_axil_wdata = 32'hA5A5_5A5A; s_axil_wstrb = 4'hF;
    #1;
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b110) begin
      failures++;
      $display("FAIL wr_grant: aw/w/ar ready=%b want 110", {s_axil_awready, s_axil_wready, s_axil_arready});
    end
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    checks++;
    if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b101 || m_apb_paddr !== 32'h3000_0010 ||
        m_apb_pstrb !== 4'hF || m_apb_pwdata !== 32'hA5A5_5A5A || m_apb_pprot !== 3'b010) begin
      failures++;
      $display("FAIL wr_setup: sel/en/wr=%b paddr=%h pstrb=%h pwdata=%h pprot=%b want 101 30000010 f a5a55a5a 010",
               {m_apb_psel, m_apb_penable, m_apb_pwrite}, m_apb_paddr, m_apb_pstrb, m_apb_pwdata, m_apb_pprot);
    end
    tick();
    checks++;
    if ({m_apb_psel, m_apb_penable, s_axil_bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL wr_access: sel/en/bvalid=%b want 110", {m_apb_psel, m_apb_penable, s_axil_bvalid});
    end
    tick();
    checks++;
    if ({s_axil_bvalid, s_axil_rvalid, m_apb_psel, m_apb_penable} !== 4'b1000 || s_axil_bresp !== 2'b00) begin
      failures++;
      $display("FAIL wr_resp: bv/rv/sel/en=%b bresp=%b want 1000 00",
               {s_axil_bvalid, s_axil_rvalid, m_apb_psel, m_apb_penable}, s_axil_bresp);
    end
    tick();
    checks++;
    if (s_axil_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle: bvalid=%b want 0", s_axil_bvalid);
    end
  endtask

  task automatic test_read_wait();
    m_apb_pready = 0; m_apb_prdata = 32'h1234_5678;
    s_axil_arvalid = 1; s_axil_araddr = 32'h3000_0020; s_axil_arprot = 3'b001;
    #1;
    checks++;
    if ({s_axil_awready, s_axil_arready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_grant: aw/ar ready=%b want 01", {s_axil_awready, s_axil_arready});
    end
    tick();
    s_axil_arvalid = 0;
    checks++;
    if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b100 || m_apb_pstrb !== 4'h0 ||
        m_apb_pwdata !== 32'h0) begin
      failures++;
      $display("FAIL rd_setup: sel/en/wr=%b pstrb=%h pwdata=%h want 100 0 0",
               {m_apb_psel, m_apb_penable, m_apb_pwrite}, m_apb_pstrb, m_apb_pwdata);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({m_apb_psel, m_apb_penable, m_apb_pwrite, s_axil_rvalid} !== 4'b1100 ||
          m_apb_paddr !== 32'h3000_0020 || m_apb_pprot !== 3'b001) begin
        failures++;
        $display("FAIL rd_wait%0d: sel/en/wr/rv=%b paddr=%h pprot=%b want 1100 30000020 001",
                 i, {m_apb_psel, m_apb_penable, m_apb_pwrite, s_axil_rvalid}, m_apb_paddr, m_apb_pprot);
      end
      tick();
    end
    m_apb_pready = 1;
    tick();
    m_apb_pready = 0;
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h1234_5678 || s_axil_rresp !== 2'b00 || m_apb_psel !== 1'b0) begin
      failures++;
      $display("FAIL rd_resp: rvalid=%b rdata=%h rresp=%b psel=%b want 1 12345678 00 0",
               s_axil_rvalid, s_axil_rdata, s_axil_rresp, m_apb_psel);
    end
    tick();
  endtask

  task automatic test_slverr();
    m_apb_pready = 1; m_apb_pslverr = 1; m_apb_prdata = 32'hDEAD_BEEF;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_awaddr = 32'h3000_0040;
    s_axil_wdata = 32'h1; s_axil_wstrb = 4'h3;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    tick(); tick();
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b10) begin
      failures++;
      $display("FAIL wr_slverr: bvalid=%b bresp=%b want 1 10", s_axil_bvalid, s_axil_bresp);
    end
    tick();
    s_axil_arvalid = 1; s_axil_araddr = 32'h3000_0044;
    tick();
    s_axil_arvalid = 0;
    tick(); tick();
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_rresp !== 2'b10 || s_axil_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_slverr: rvalid=%b rresp=%b rdata=%h want 1 10 deadbeef",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end
    tick();
    m_apb_pslverr = 0;
  endtask

  task automatic test_timeout();
    m_apb_pready = 0; m_apb_prdata = 32'hCAFE_F00D;
    s_axil_arvalid = 1; s_axil_araddr = 32'h3000_0080;
    tick();
    s_axil_arvalid = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({m_apb_psel, m_apb_penable, s_axil_rvalid} !== 3'b110) begin
        failures++;
        $display("FAIL tmo_access%0d: sel/en/rv=%b want 110", i, {m_apb_psel, m_apb_penable, s_axil_rvalid});
      end
      tick();
    end
    checks++;
    if ({s_axil_rvalid, m_apb_psel, m_apb_penable} !== 3'b100 || s_axil_rresp !== 2'b11 ||
        s_axil_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_resp: rv/sel/en=%b rresp=%b rdata=%h want 100 11 00000000",
               {s_axil_rvalid, m_apb_psel, m_apb_penable}, s_axil_rresp, s_axil_rdata);
    end
    tick();
    m_apb_pready = 1;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_awaddr = 32'h3000_0084;
    s_axil_wdata = 32'h55; s_axil_wstrb = 4'h1;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    tick(); tick();
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      failures++;
      $display("FAIL tmo_recover: bvalid=%b bresp=%b want 1 00", s_axil_bvalid, s_axil_bresp);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_wr;
    exp_wr = 4'b1010;
    core_rst = 1; m_apb_pready = 1;
    tick();
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
    s_axil_awaddr = 32'h3000_0100; s_axil_araddr = 32'h3000_0200;
    tick();
    core_rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== {exp_wr[i], exp_wr[i], ~exp_wr[i]}) begin
        failures++;
        $display("FAIL rr_grant%0d: aw/w/ar ready=%b want %b", i,
                 {s_axil_awready, s_axil_wready, s_axil_arready}, {exp_wr[i], exp_wr[i], ~exp_wr[i]});
      end
      tick(); tick(); tick(); tick();
    end
    s_axil_awvalid = 1; s_axil_wvalid = 0; s_axil_arvalid = 0;
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({s_axil_awready, s_axil_wready, m_apb_psel} !== 3'b000) begin
        failures++;
        $display("FAIL aw_only%0d: aw/w ready, psel=%b want 000", i, {s_axil_awready, s_axil_wready, m_apb_psel});
      end
      tick();
    end
    s_axil_awvalid = 0;
  endtask

  task automatic test_reset_mid();
    m_apb_pready = 0;
    s_axil_arvalid = 1; s_axil_araddr = 32'h3000_0300;
    tick();
    s_axil_arvalid = 0;
    tick();
    checks++;
    if ({m_apb_psel, m_apb_penable} !== 2'b11) begin
      failures++;
      $display("FAIL mid_access: sel/en=%b want 11", {m_apb_psel, m_apb_penable});
    end
    core_rst = 1;
    tick();
    core_rst = 0;
    m_apb_pready = 1;
    checks++;
    if ({m_apb_psel, m_apb_penable, s_axil_bvalid, s_axil_rvalid} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst: sel/en/bv/rv=%b want 0000", {m_apb_psel, m_apb_penable, s_axil_bvalid, s_axil_rvalid});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({s_axil_bvalid, s_axil_rvalid, m_apb_psel} !== 3'b000) begin
        failures++;
        $display("FAIL mid_quiet%0d: bv/rv/sel=%b want 000", i, {s_axil_bvalid, s_axil_rvalid, m_apb_psel});
      end
    end
    m_apb_prdata = 32'h0BAD_F00D;
    s_axil_arvalid = 1; s_axil_araddr = 32'h3000_0304;
    tick();
    s_axil_arvalid = 0;
    tick(); tick();
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h0BAD_F00D || s_axil_rresp !== 2'b00) begin
      failures++;
      $display("FAIL mid_after: rvalid=%b rdata=%h rresp=%b want 1 0badf00d 00",
               s_axil_rvalid, s_axil_rdata, s_axil_rresp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
